// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl -- interrupt scheduler for four DW-bit cpu input ports.
//
// Watches d0_e..d3_e for value changes. Each change latches a per-port pending
// flag and a snapshot of the new value. One request at a time is arbitrated
// among the unmasked pending ports and offered to the cpu over an
// irq / irq_ack / irq_eoi handshake.
//
// Optional feature macro: IRQ_TIMEOUT_EN
//   When defined, an unacknowledged request is withdrawn after TIMEOUT_CYC
//   cycles in REQ. irq_to pulses for one cycle and the pending flag is kept.
//   When undefined, REQ waits indefinitely and irq_to is tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   d0_e..d3_e     in   monitored input ports, DW bits each
//   mask_we        in   mask register write strobe
//   mask_in        in   new mask, bit k = 1 blocks requests from port k
//   irq_ack        in   cpu acknowledge (REQ -> SERVICE)
//   irq_eoi        in   cpu end of interrupt (SERVICE -> IDLE)
//   irq            out  interrupt request
//   irq_id         out  index of the requesting port
//   irq_data       out  snapshot of the requesting port
//   pending        out  raw pending flags, unmasked view
//   busy           out  high while in SERVICE
//   irq_to         out  one-cycle request timeout pulse
module io_irq_ctrl #(
  parameter int DW          = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] d0_e,
  input  logic [DW-1:0] d1_e,
  input  logic [DW-1:0] d2_e,
  input  logic [DW-1:0] d3_e,
  input  logic          mask_we,
  input  logic [3:0]    mask_in,
  input  logic          irq_ack,
  input  logic          irq_eoi,
  output logic          irq,
  output logic [1:0]    irq_id,
  output logic [DW-1:0] irq_data,
  output logic [3:0]    pending,
  output logic          busy,
  output logic          irq_to
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  // Returns {found, index}: first set bit of req, searching upward from start
  // and wrapping 3 -> 0.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [DW-1:0] d_in [4];
  // The last value seen on a port is, by construction, also its latest changed
  // value, so a single register serves as both change reference and snapshot.
  logic [DW-1:0] last_q [4];
  logic [3:0]    chg;
  logic [3:0]    pend_q, pend_d, clr;
  logic [3:0]    mask_q;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    state_q, state_d;
  logic          irq_q, irq_d;
  logic [1:0]    irq_id_q, irq_id_d;
  logic [DW-1:0] irq_data_q, irq_data_d;
  logic          busy_q, busy_d;
  logic [1:0]    start;
  logic [2:0]    win;

  assign d_in[0] = d0_e;
  assign d_in[1] = d1_e;
  assign d_in[2] = d2_e;
  assign d_in[3] = d3_e;

  always_comb begin
    for (int k = 0; k < 4; k++) chg[k] = (d_in[k] != last_q[k]);
  end

  assign start = (ROUND_ROBIN != 0) ? rr_ptr_q + 2'd1 : 2'd0;
  assign win   = pick(pend_q & ~mask_q, start);

`ifdef IRQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    irq_data_d = irq_data_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    clr        = '0;
`ifdef IRQ_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win[2]) begin
          irq_d      = 1'b1;
          irq_id_d   = win[1:0];
          irq_data_d = last_q[win[1:0]];
          state_d    = REQ;
`ifdef IRQ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      REQ: begin
        // Ack wins over a simultaneous eoi; the mask is not consulted here.
        if (irq_ack) begin
          clr[irq_id_q] = 1'b1;
          rr_ptr_d      = irq_id_q;
          irq_d         = 1'b0;
          busy_d        = 1'b1;
          state_d       = SERVICE;
        end
`ifdef IRQ_TIMEOUT_EN
        // Counter tracks completed REQ cycles, so irq is high for exactly
        // TIMEOUT_CYC cycles before being withdrawn.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          irq_d    = 1'b0;
          to_d     = 1'b1;
          rr_ptr_d = irq_id_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SERVICE: begin
        if (irq_eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new change wins over a same-cycle clear by ack.
    pend_d = (pend_q & ~clr) | chg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      irq_data_q <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= 2'd3;
      pend_q     <= '0;
      mask_q     <= 4'hF;
      for (int k = 0; k < 4; k++) last_q[k] <= '0;
`ifdef IRQ_TIMEOUT_EN
      cnt_q      <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      irq_data_q <= irq_data_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      pend_q     <= pend_d;
      if (mask_we) mask_q <= mask_in;
      for (int k = 0; k < 4; k++) begin
        if (chg[k]) last_q[k] <= d_in[k];
      end
`ifdef IRQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign irq      = irq_q;
  assign irq_id   = irq_id_q;
  assign irq_data = irq_data_q;
  assign pending  = pend_q;
  assign busy     = busy_q;
`ifdef IRQ_TIMEOUT_EN
  assign irq_to   = to_q;
`else
  assign irq_to   = 1'b0;
`endif

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Testbench for io_irq_ctrl: a fixed-priority instance (TIMEOUT_CYC=4) and a
// rotating-priority instance. Grants are checked by a scoreboard monitor on
// each rising irq; state flags are checked directly by the stimulus thread.
module tb_io_irq_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] f_d0, f_d1, f_d2, f_d3;
  logic          f_we, f_ack, f_eoi;
  logic [3:0]    f_mi;
  logic          f_irq, f_busy, f_to;
  logic [1:0]    f_id;
  logic [DW-1:0] f_data;
  logic [3:0]    f_pend;

  logic [DW-1:0] r_d0, r_d1, r_d2, r_d3;
  logic          r_we, r_ack, r_eoi;
  logic [3:0]    r_mi;
  logic          r_irq, r_busy, r_to;
  logic [1:0]    r_id;
  logic [DW-1:0] r_data;
  logic [3:0]    r_pend;

  io_irq_ctrl #(.DW(DW), .ROUND_ROBIN(0), .TIMEOUT_CYC(4)) dut_fx (
    .clk(clk), .reset(rst_n),
    .d0_e(f_d0), .d1_e(f_d1), .d2_e(f_d2), .d3_e(f_d3),
    .mask_we(f_we), .mask_in(f_mi), .irq_ack(f_ack), .irq_eoi(f_eoi),
    .irq(f_irq), .irq_id(f_id), .irq_data(f_data), .pending(f_pend),
    .busy(f_busy), .irq_to(f_to)
  );

  io_irq_ctrl #(.DW(DW), .ROUND_ROBIN(1), .TIMEOUT_CYC(4)) dut_rr (
    .clk(clk), .reset(rst_n),
    .d0_e(r_d0), .d1_e(r_d1), .d2_e(r_d2), .d3_e(r_d3),
    .mask_we(r_we), .mask_in(r_mi), .irq_ack(r_ack), .irq_eoi(r_eoi),
    .irq(r_irq), .irq_id(r_id), .irq_data(r_data), .pending(r_pend),
    .busy(r_busy), .irq_to(r_to)
  );

  int         checks = 0;
  int         errors = 0;
  logic [9:0] fq [$];
  logic [9:0] rq [$];
  logic       f_prev, r_prev;
  logic [9:0] e_f, e_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input bit sel);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (sel ? r_irq : f_irq) got = 1'b1;
      else tick(1);
    end
    check(sel ? "rr_irq_wait" : "fx_irq_wait", 32'(got), 32'd1);
  endtask

  task automatic serve_fx();
    wait_irq(1'b0);
    f_ack = 1'b1;
    tick(1);
    f_ack = 1'b0;
    f_eoi = 1'b1;
    tick(1);
    f_eoi = 1'b0;
  endtask

  // Serve one rotating-mode grant, optionally re-triggering a port while
  // the grant is in SERVICE.
  task automatic serve_rr(input bit rt, input bit port, input logic [DW-1:0] v);
    wait_irq(1'b1);
    r_ack = 1'b1;
    tick(1);
    r_ack = 1'b0;
    if (rt) begin
      if (port) r_d1 = v;
      else      r_d0 = v;
    end
    r_eoi = 1'b1;
    tick(1);
    r_eoi = 1'b0;
  endtask

  initial begin
    f_prev = 1'b0;
    r_prev = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (f_irq && !f_prev) begin
          if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fx_unexpected_irq actual id=%0d data=%0h required no request", f_id, f_data);
          end else begin
            e_f = fq.pop_front();
            check("fx_grant", 32'({f_id, f_data}), 32'(e_f));
          end
        end
        if (r_irq && !r_prev) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rr_unexpected_irq actual id=%0d data=%0h required no request", r_id, r_data);
          end else begin
            e_r = rq.pop_front();
            check("rr_grant", 32'({r_id, r_data}), 32'(e_r));
          end
        end
        f_prev = f_irq;
        r_prev = r_irq;
      end
    join_none

    rst_n = 1'b0;
    {f_d0, f_d1, f_d2, f_d3} = '0;
    {r_d0, r_d1, r_d2, r_d3} = '0;
    {f_we, f_ack, f_eoi, r_we, r_ack, r_eoi} = '0;
    f_mi = '0;
    r_mi = '0;
    tick(2);
    check("rst_irq",  32'(f_irq),  32'd0);
    check("rst_id",   32'(f_id),   32'd0);
    check("rst_data", 32'(f_data), 32'd0);
    check("rst_pend", 32'(f_pend), 32'd0);
    check("rst_busy", 32'(f_busy), 32'd0);
    check("rst_to",   32'(f_to),   32'd0);

    rst_n = 1'b1;
    f_we = 1'b1; f_mi = 4'h0;
    r_we = 1'b1; r_mi = 4'h0;
    tick(1);
    f_we = 1'b0; r_we = 1'b0;

    // Single change on port 2
    f_d2 = 8'h15;
    fq.push_back({2'd2, 8'h15});
    tick(1);
    check("p2_pend", 32'(f_pend), 32'h4);
    check("p2_irq_not_yet", 32'(f_irq), 32'd0);
    tick(1);
    check("p2_irq", 32'(f_irq), 32'd1);
    f_ack = 1'b1;
    tick(1);
    f_ack = 1'b0;
    check("p2_ack_pend", 32'(f_pend), 32'h0);
    check("p2_ack_busy", 32'(f_busy), 32'd1);
    check("p2_ack_irq",  32'(f_irq),  32'd0);
    f_eoi = 1'b1;
    tick(1);
    f_eoi = 1'b0;
    check("p2_eoi_busy", 32'(f_busy), 32'd0);
    check("p2_eoi_irq",  32'(f_irq),  32'd0);

    // Simultaneous changes on ports 1 and 3: fixed priority
    f_d1 = 8'hA1;
    f_d3 = 8'h3C;
    fq.push_back({2'd1, 8'hA1});
    fq.push_back({2'd3, 8'h3C});
    tick(1);
    check("p13_pend", 32'(f_pend), 32'hA);
    serve_fx();
    check("p13_pend_after1", 32'(f_pend), 32'h8);
    serve_fx();
    check("p13_pend_after2", 32'(f_pend), 32'h0);

    // Masked port latches pending but does not request
    f_we = 1'b1; f_mi = 4'b0001;
    tick(1);
    f_we = 1'b0;
    f_d0 = 8'h55;
    fq.push_back({2'd0, 8'h55});
    tick(2);
    check("mask_pend", 32'(f_pend), 32'h1);
    check("mask_irq",  32'(f_irq),  32'd0);
    f_we = 1'b1; f_mi = 4'h0;
    tick(1);
    f_we = 1'b0;
    serve_fx();

    // Change on the requesting port in the ack cycle
    f_d0 = 8'h11;
    fq.push_back({2'd0, 8'h11});
    tick(2);
    check("soc_irq", 32'(f_irq), 32'd1);
    f_ack = 1'b1;
    f_d0 = 8'h22;
    fq.push_back({2'd0, 8'h22});
    tick(1);
    f_ack = 1'b0;
    check("soc_pend", 32'(f_pend), 32'h1);
    check("soc_busy", 32'(f_busy), 32'd1);
    f_eoi = 1'b1;
    tick(1);
    f_eoi = 1'b0;
    serve_fx();
    check("soc_pend_done", 32'(f_pend), 32'h0);

    // Rotating priority: ports 0 and 1 kept pending, grants alternate
    r_d0 = 8'h01;
    r_d1 = 8'h02;
    rq.push_back({2'd0, 8'h01});
    rq.push_back({2'd1, 8'h02});
    rq.push_back({2'd0, 8'h11});
    rq.push_back({2'd1, 8'h12});
    rq.push_back({2'd0, 8'h21});
    serve_rr(1'b1, 1'b0, 8'h11);
    serve_rr(1'b1, 1'b1, 8'h12);
    serve_rr(1'b1, 1'b0, 8'h21);
    serve_rr(1'b0, 1'b0, 8'h00);
    serve_rr(1'b0, 1'b0, 8'h00);
    check("rr_pend_done", 32'(r_pend), 32'h0);
    check("rr_busy_done", 32'(r_busy), 32'd0);
    check("rr_to_idle",   32'(r_to),   32'd0);

    // Reset during SERVICE
    f_d3 = 8'h77;
    fq.push_back({2'd3, 8'h77});
    wait_irq(1'b0);
    f_ack = 1'b1;
    tick(1);
    f_ack = 1'b0;
    check("svc_busy", 32'(f_busy), 32'd1);
    rst_n = 1'b0;
    {f_d0, f_d1, f_d3} = '0;
    f_d2 = 8'h40;
    {r_d0, r_d1, r_d2, r_d3} = '0;
    #1;
    check("mid_rst_irq",  32'(f_irq),  32'd0);
    check("mid_rst_id",   32'(f_id),   32'd0);
    check("mid_rst_data", 32'(f_data), 32'd0);
    check("mid_rst_pend", 32'(f_pend), 32'd0);
    check("mid_rst_busy", 32'(f_busy), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_pend", 32'(f_pend), 32'h4);
    tick(1);
    check("post_rst_masked", 32'(f_irq), 32'd0);

    // Request held without ack
    fq.push_back({2'd2, 8'h40});
    f_we = 1'b1; f_mi = 4'h0;
    tick(1);
    f_we = 1'b0;
    tick(1);
    check("to_irq_up", 32'(f_irq), 32'd1);
`ifdef IRQ_TIMEOUT_EN
    tick(3);
    check("to_irq_held", 32'(f_irq), 32'd1);
    check("to_no_pulse", 32'(f_to),  32'd0);
    tick(1);
    check("to_irq_drop", 32'(f_irq),  32'd0);
    check("to_pulse",    32'(f_to),   32'd1);
    check("to_pend",     32'(f_pend), 32'h4);
    fq.push_back({2'd2, 8'h40});
    tick(1);
    check("to_pulse_end", 32'(f_to),  32'd0);
    check("to_rewin",     32'(f_irq), 32'd1);
`else
    tick(6);
    check("to_irq_held", 32'(f_irq), 32'd1);
    check("to_tied_0",   32'(f_to),  32'd0);
`endif
    serve_fx();
    check("end_pend", 32'(f_pend), 32'h0);

    tick(3);
    check("fx_queue_drained", 32'(fq.size()), 32'd0);
    check("rr_queue_drained", 32'(rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
